writeback_regfile: RTL and testbench
====================================

Name: writeback_regfile

Overview:
- Writeback stage and register file of the sequential Y86-64 core. Sits directly downstream of the memory stage.
- Consumes icode, cnd, rA, rB, valE and valM for the retiring instruction and commits results to the 15 program registers on the clock edge.
- Provides two combinational read ports to the decode stage.
- Holds the sticky processor status (AOK/HLT/ADR/INS) and a retired-instruction counter.

Parameters:
- DATA_W, 64, register and value width
- NREGS, 15, number of architectural registers (ids 0..14); id 4'hF = RNONE
- CNT_W, 64, width of retired-instruction counter

Ports:
- clk  input  1  core clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- wb_valid  input  1  retiring instruction present this cycle
- icode  input  4  instruction code of retiring instruction
- cnd  input  1  condition result from execute (cmovXX gating)
- rA  input  4  rA field
- rB  input  4  rB field
- valE  input  DATA_W  execute result
- valM  input  DATA_W  memory-stage read data
- mem_err  input  1  memory stage address error for this instruction
- srcA  input  4  decode read address A
- srcB  input  4  decode read address B
- rvalA  output  DATA_W  register[srcA]; 0 when srcA=F
- rvalB  output  DATA_W  register[srcB]; 0 when srcB=F
- stat  output  2  00 AOK, 01 HLT, 10 ADR, 11 INS
- halted  output  1  high when stat != AOK
- retired  output  CNT_W  count of committed instructions

Behaviour:
- Reset (async assert): all 15 registers = 0, stat = AOK, halted = 0, retired = 0. Deassertion is taken on the next rising clk.
- Commit condition: wb_valid & (stat == AOK).
- dstE selection:
  - rB for irmovq (3) and OPq (6).
  - rB for cmovXX/rrmovq (2) only if cnd = 1, else F.
  - 4 (%rsp) for call (8), ret (9), pushq (A), popq (B).
  - F otherwise.
- dstM selection: rA for mrmovq (5) and popq (B); F otherwise.
- On commit edge:
  - reg[dstE] <= valE if dstE != F.
  - reg[dstM] <= valM if dstM != F.
  - If dstE == dstM (popq %rsp), valM wins.
  - Latency is one edge; values are visible on the read ports in the following cycle.
- Status update on commit edge, priority highest first:
  1. mem_err: stat <= ADR, no register writes.
  2. icode > B: stat <= INS, no writes.
  3. icode == 0 (halt): stat <= HLT.
  4. Otherwise stat stays AOK.
- stat is sticky. Once non-AOK, all writes and counting are frozen until rst.
- retired increments by 1 on every commit edge, including the faulting or halting instruction. Wraps modulo 2^CNT_W.
- wb_valid = 0: no state change.
- Read ports are purely combinational from the register array. Address F reads 0.
- Reset during operation aborts any pending write; the register array is zeroed immediately.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: rvalA/rvalB forward the value being written this cycle when srcX matches an active dstE/dstM under the commit condition, using the same valM-over-valE priority. Decode then sees same-cycle results.
- Undefined: reads return the array contents only; the written value appears after the edge.

Test Plan:
- Reset with array preloaded nonzero -> all rvalA/rvalB reads 0, stat = 00, retired = 0.
- irmovq: wb_valid=1, icode=3, rB=2, valE=0x1234 -> after edge, srcA=2 reads 0x1234, retired = 1.
- cmovXX: icode=2, rB=3, valE=5, cnd=0 -> reg3 unchanged. Repeat with cnd=1 -> reg3 = 5.
- popq %rsp: icode=B, rA=4, valE=0x108, valM=0x55 -> reg4 = 0x55. popq rA=1 -> reg4 = 0x108, reg1 = 0x55.
- mem_err=1 on mrmovq (icode=5, rA=6, valM=0x99) -> stat = ADR, halted = 1, reg6 unchanged. Following irmovq is ignored and retired stays frozen. rst restores AOK.
- icode=0 -> stat = HLT after edge. icode=0xC on a fresh run -> stat = INS. Neither writes any register.

Source files
------------

// File: rtl/writeback_regfile.sv
// writeback_regfile: Y86-64 writeback stage, 15-entry register file, sticky status and retired counter.
// Optional RF_BYPASS_EN forwards same-cycle writes onto the read ports.
module writeback_regfile #(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [3:0]        icode,
    input  logic              cnd,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic              mem_err,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] rvalA,
    output logic [DATA_W-1:0] rvalB,
    output logic [1:0]        stat,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [1:0] AOK = 2'b00, HLT = 2'b01, ADR = 2'b10, INS = 2'b11;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [1:0]        stat_q, stat_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [3:0]        dst_e, dst_m;
    logic              commit, fault, we_e, we_m;

    always_comb begin
        dst_e = (icode == 4'h3 || icode == 4'h6 || (icode == 4'h2 && cnd)) ? rB :
                (icode >= 4'h8 && icode <= 4'hB) ? RSP : RNONE;
        dst_m = (icode == 4'h5 || icode == 4'hB) ? rA : RNONE;
        commit = wb_valid && stat_q == AOK;
        fault = mem_err || icode > 4'hB;
        we_e = commit && !fault && dst_e != RNONE;
        we_m = commit && !fault && dst_m != RNONE;
        stat_d = !commit ? stat_q : mem_err ? ADR : icode > 4'hB ? INS :
                 icode == 4'h0 ? HLT : AOK;
        retired_d = retired_q + CNT_W'(commit);
    end

    // valM write is issued last so it wins when dstE == dstM (popq %rsp)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            stat_q    <= AOK;
            retired_q <= '0;
        end else begin
            if (we_e) regs_q[dst_e] <= valE;
            if (we_m) regs_q[dst_m] <= valM;
            stat_q    <= stat_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
`ifdef RF_BYPASS_EN
        rvalA = srcA == RNONE ? '0 : (we_m && srcA == dst_m) ? valM :
                (we_e && srcA == dst_e) ? valE : regs_q[srcA];
        rvalB = srcB == RNONE ? '0 : (we_m && srcB == dst_m) ? valM :
                (we_e && srcB == dst_e) ? valE : regs_q[srcB];
`else
        rvalA = srcA == RNONE ? '0 : regs_q[srcA];
        rvalB = srcB == RNONE ? '0 : regs_q[srcB];
`endif
    end

    assign stat    = stat_q;
    assign halted  = stat_q != AOK;
    assign retired = retired_q;
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: directed checks of commit, dst selection, status and reset behaviour.
module tb_writeback_regfile;
    logic        clk = 0, rst = 1, wb_valid = 0, cnd = 0, mem_err = 0;
    logic [3:0]  icode = 0, rA = 4'hF, rB = 4'hF, srcA = 4'hF, srcB = 4'hF;
    logic [63:0] valE = 0, valM = 0, rvalA, rvalB, retired;
    logic [1:0]  stat;
    logic        halted;
    int errors = 0, checks = 0;

    writeback_regfile dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .icode(icode), .cnd(cnd),
        .rA(rA), .rB(rB), .valE(valE), .valM(valM), .mem_err(mem_err),
        .srcA(srcA), .srcB(srcB), .rvalA(rvalA), .rvalB(rvalB),
        .stat(stat), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [3:0] ic, input logic c, input logic [3:0] a,
                        input logic [3:0] b, input logic [63:0] e, input logic [63:0] m,
                        input logic err);
        @(negedge clk);
        icode = ic; cnd = c; rA = a; rB = b; valE = e; valM = m; mem_err = err;
        wb_valid = 1;
        @(posedge clk);
        #1 wb_valid = 0; mem_err = 0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [3:0] b);
        srcA = a; srcB = b;
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1;
        #2 rst = 0;
    endtask

    task automatic test_reset;
        do_reset();
        step(4'h3, 0, 4'hF, 4'h1, 64'hAAAA, 0, 0);
        step(4'h3, 0, 4'hF, 4'h2, 64'hBBBB, 0, 0);
        @(negedge clk);
        rst = 1;
        rd(4'h1, 4'h2);
        checks++; if (rvalA !== 64'h0) begin errors++; $display("FAIL reset_reg1 got=%h exp=0", rvalA); end
        checks++; if (rvalB !== 64'h0) begin errors++; $display("FAIL reset_reg2 got=%h exp=0", rvalB); end
        checks++; if (stat !== 2'b00 || halted !== 1'b0) begin errors++; $display("FAIL reset_stat got=%b/%b exp=00/0", stat, halted); end
        checks++; if (retired !== 64'd0) begin errors++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        #2 rst = 0;
    endtask

    task automatic test_irmovq;
        do_reset();
        step(4'h3, 0, 4'hF, 4'h2, 64'h1234, 64'hDEAD, 0);
        rd(4'h2, 4'hF);
        checks++; if (rvalA !== 64'h1234) begin errors++; $display("FAIL irmovq_reg2 got=%h exp=1234", rvalA); end
        checks++; if (rvalB !== 64'h0) begin errors++; $display("FAIL rnone_read got=%h exp=0", rvalB); end
        checks++; if (retired !== 64'd1) begin errors++; $display("FAIL irmovq_retired got=%0d exp=1", retired); end
        @(negedge clk);
        icode = 4'h3; rB = 4'h2; valE = 64'h9999;
        @(posedge clk); #1;
        rd(4'h2, 4'h2);
        checks++; if (rvalA !== 64'h1234 || retired !== 64'd1) begin errors++; $display("FAIL idle_nochange got=%h/%0d exp=1234/1", rvalA, retired); end
    endtask

    task automatic test_cmov;
        do_reset();
        step(4'h2, 0, 4'h1, 4'h3, 64'h5, 0, 0);
        rd(4'h3, 4'hF);
        checks++; if (rvalA !== 64'h0) begin errors++; $display("FAIL cmov_cnd0 got=%h exp=0", rvalA); end
        checks++; if (retired !== 64'd1) begin errors++; $display("FAIL cmov_cnd0_retired got=%0d exp=1", retired); end
        step(4'h2, 1, 4'h1, 4'h3, 64'h5, 0, 0);
        rd(4'h3, 4'hF);
        checks++; if (rvalA !== 64'h5) begin errors++; $display("FAIL cmov_cnd1 got=%h exp=5", rvalA); end
    endtask

    task automatic test_popq;
        do_reset();
        step(4'hB, 0, 4'h4, 4'hF, 64'h108, 64'h55, 0);
        rd(4'h4, 4'hF);
        checks++; if (rvalA !== 64'h55) begin errors++; $display("FAIL popq_rsp got=%h exp=55", rvalA); end
        step(4'hB, 0, 4'h1, 4'hF, 64'h108, 64'h55, 0);
        rd(4'h4, 4'h1);
        checks++; if (rvalA !== 64'h108) begin errors++; $display("FAIL popq_rsp_valE got=%h exp=108", rvalA); end
        checks++; if (rvalB !== 64'h55) begin errors++; $display("FAIL popq_reg1 got=%h exp=55", rvalB); end
        step(4'h8, 0, 4'hF, 4'hF, 64'h200, 64'h7, 0);
        step(4'h5, 0, 4'h7, 4'h1, 64'h33, 64'h77, 0);
        step(4'h6, 0, 4'h0, 4'h5, 64'h66, 64'h1, 0);
        rd(4'h4, 4'h7);
        checks++; if (rvalA !== 64'h200) begin errors++; $display("FAIL call_rsp got=%h exp=200", rvalA); end
        checks++; if (rvalB !== 64'h77) begin errors++; $display("FAIL mrmovq_reg7 got=%h exp=77", rvalB); end
        rd(4'h5, 4'h1);
        checks++; if (rvalA !== 64'h66 || rvalB !== 64'h55) begin errors++; $display("FAIL opq_reg5 got=%h/%h exp=66/55", rvalA, rvalB); end
        checks++; if (retired !== 64'd5) begin errors++; $display("FAIL popq_retired got=%0d exp=5", retired); end
    endtask

    task automatic test_mem_err;
        do_reset();
        step(4'h3, 0, 4'hF, 4'h6, 64'h11, 0, 0);
        step(4'h5, 0, 4'h6, 4'h1, 64'h0, 64'h99, 1);
        rd(4'h6, 4'hF);
        checks++; if (stat !== 2'b10 || halted !== 1'b1) begin errors++; $display("FAIL adr_stat got=%b/%b exp=10/1", stat, halted); end
        checks++; if (rvalA !== 64'h11) begin errors++; $display("FAIL adr_reg6 got=%h exp=11", rvalA); end
        checks++; if (retired !== 64'd2) begin errors++; $display("FAIL adr_retired got=%0d exp=2", retired); end
        step(4'h3, 0, 4'hF, 4'h8, 64'hAA, 0, 0);
        rd(4'h8, 4'hF);
        checks++; if (rvalA !== 64'h0 || retired !== 64'd2 || stat !== 2'b10) begin errors++; $display("FAIL adr_frozen got=%h/%0d/%b exp=0/2/10", rvalA, retired, stat); end
        do_reset();
        #1;
        checks++; if (stat !== 2'b00 || halted !== 1'b0) begin errors++; $display("FAIL adr_rst got=%b/%b exp=00/0", stat, halted); end
    endtask

    task automatic test_halt;
        do_reset();
        step(4'h3, 0, 4'hF, 4'h9, 64'h3, 0, 0);
        step(4'h0, 1, 4'h9, 4'h9, 64'hFF, 64'hEE, 0);
        rd(4'h9, 4'h4);
        checks++; if (stat !== 2'b01 || halted !== 1'b1) begin errors++; $display("FAIL hlt_stat got=%b/%b exp=01/1", stat, halted); end
        checks++; if (rvalA !== 64'h3 || rvalB !== 64'h0) begin errors++; $display("FAIL hlt_nowrite got=%h/%h exp=3/0", rvalA, rvalB); end
        checks++; if (retired !== 64'd2) begin errors++; $display("FAIL hlt_retired got=%0d exp=2", retired); end
        step(4'h3, 0, 4'hF, 4'h9, 64'h44, 0, 0);
        rd(4'h9, 4'hF);
        checks++; if (rvalA !== 64'h3 || retired !== 64'd2) begin errors++; $display("FAIL hlt_frozen got=%h/%0d exp=3/2", rvalA, retired); end
    endtask

    task automatic test_ins;
        do_reset();
        step(4'hC, 1, 4'hA, 4'hA, 64'h12, 64'h34, 0);
        rd(4'hA, 4'h4);
        checks++; if (stat !== 2'b11 || halted !== 1'b1) begin errors++; $display("FAIL ins_stat got=%b/%b exp=11/1", stat, halted); end
        checks++; if (rvalA !== 64'h0 || rvalB !== 64'h0) begin errors++; $display("FAIL ins_nowrite got=%h/%h exp=0/0", rvalA, rvalB); end
        checks++; if (retired !== 64'd1) begin errors++; $display("FAIL ins_retired got=%0d exp=1", retired); end
    endtask

    initial begin
        test_reset();
        test_irmovq();
        test_cmov();
        test_popq();
        test_mem_err();
        test_halt();
        test_ins();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
